// File: rtl/perip_bus_arbiter.sv
// Two-master arbiter for the shared peripheral bus (data RAM + GPIO).
// Build option: define PERIP_ARB_RR_EN for round-robin tie breaking; otherwise master 0 wins ties.
module perip_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_wr_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic          m0_lock_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_wr_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic          m1_lock_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          s_rd_en_o,
    output logic [AW-1:0] s_rd_addr_o,
    output logic [3:0]    s_wr_sel_o,
    output logic [AW-1:0] s_wr_addr_o,
    output logic [DW-1:0] s_wr_data_o,
    input  logic [DW-1:0] s_rd_data_i,
    output logic          busy_o,
    output logic [1:0]    state_o
);

    // Handshake: a master holds req and its command stable until it sees gnt;
    // gnt is combinational and the transfer commits at the clock edge where gnt=1.
    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   rsp_vld;
    logic   rsp_id;
`ifdef PERIP_ARB_RR_EN
    logic   last_winner;
`endif

    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic          sel_we;
    logic [3:0]    sel_wr_sel;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          rd_gnt;
    logic          wr_gnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OWN0: gnt0 = m0_req_i;
            OWN1: gnt1 = m1_req_i;
            default: begin
                if (m0_req_i && m1_req_i) begin
`ifdef PERIP_ARB_RR_EN
                    gnt0 = last_winner;
                    gnt1 = !last_winner;
`else
                    gnt0 = 1'b1;
`endif
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
            end
        endcase
    end

    assign any_gnt    = gnt0 || gnt1;
    assign sel_we     = gnt1 ? m1_we_i     : m0_we_i;
    assign sel_wr_sel = gnt1 ? m1_wr_sel_i : m0_wr_sel_i;
    assign sel_addr   = gnt1 ? m1_addr_i   : m0_addr_i;
    assign sel_wdata  = gnt1 ? m1_wdata_i  : m0_wdata_i;
    assign rd_gnt     = any_gnt && !sel_we;
    assign wr_gnt     = any_gnt && sel_we;

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign s_rd_en_o   = rd_gnt;
    assign s_rd_addr_o = rd_gnt ? sel_addr   : '0;
    assign s_wr_sel_o  = wr_gnt ? sel_wr_sel : 4'h0;
    assign s_wr_addr_o = wr_gnt ? sel_addr   : '0;
    assign s_wr_data_o = wr_gnt ? sel_wdata  : '0;

    // Read data is steered by the tag captured at the read grant.
    assign m0_rvalid_o = rsp_vld && !rsp_id;
    assign m1_rvalid_o = rsp_vld && rsp_id;
    assign m0_rdata_o  = m0_rvalid_o ? s_rd_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rd_data_i : '0;

    assign busy_o  = (state != FREE) || rsp_vld;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FREE;
            rsp_vld <= 1'b0;
            rsp_id  <= 1'b0;
`ifdef PERIP_ARB_RR_EN
            last_winner <= 1'b1;
`endif
        end else begin
            rsp_vld <= rd_gnt;
            if (rd_gnt) rsp_id <= gnt1;
            case (state)
                FREE: begin
                    if (gnt0 && m0_lock_i)      state <= OWN0;
                    else if (gnt1 && m1_lock_i) state <= OWN1;
`ifdef PERIP_ARB_RR_EN
                    if (any_gnt) last_winner <= gnt1;
`endif
                end
                // In OWNn the owner is granted whenever it requests, so
                // dropping req or lock both release the bus.
                OWN0: if (!m0_req_i || !m0_lock_i) state <= FREE;
                OWN1: if (!m1_req_i || !m1_lock_i) state <= FREE;
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Directed bench for perip_bus_arbiter; read responses are checked through an expected queue.
module tb_perip_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_rd_en;
    logic [31:0] s_rd_addr, s_wr_addr, s_wr_data, s_rd_data;
    logic [3:0]  s_wr_sel;
    logic        busy;
    logic [1:0]  state;

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic        rsp_pend;
    logic [31:0] pend_d;
    logic [31:0] nxt_rd;
    int          tie_w[4];
    int          w;

    perip_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wr_sel_i(m0_sel), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wd), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_wr_sel_i(m1_sel), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wd), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .s_rd_en_o(s_rd_en), .s_rd_addr_o(s_rd_addr), .s_wr_sel_o(s_wr_sel),
        .s_wr_addr_o(s_wr_addr), .s_wr_data_o(s_wr_data), .s_rd_data_i(s_rd_data),
        .busy_o(busy), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int n, input logic req, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd, input logic lock);
        if (n == 0) begin
            m0_req = req; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wd = wd; m0_lock = lock;
        end else begin
            m1_req = req; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wd = wd; m1_lock = lock;
        end
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, then advances one clock.
    task automatic tick(input logic eg0, input logic eg1, input logic ebusy);
        logic        any, we;
        logic [3:0]  sel;
        logic [31:0] addr, wd;
        logic [32:0] e;
        #1;
        chk("gnt0", m0_gnt, eg0);
        chk("gnt1", m1_gnt, eg1);
        any  = eg0 | eg1;
        we   = eg1 ? m1_we   : m0_we;
        sel  = eg1 ? m1_sel  : m0_sel;
        addr = eg1 ? m1_addr : m0_addr;
        wd   = eg1 ? m1_wd   : m0_wd;
        chk("s_rd_en", s_rd_en, any && !we);
        chk("s_wr_sel", s_wr_sel, (any && we) ? sel : 4'h0);
        if (!(any && we)) chk("s_rd_addr", s_rd_addr, any ? addr : 32'h0);
        if (!(any && !we)) begin
            chk("s_wr_addr", s_wr_addr, any ? addr : 32'h0);
            chk("s_wr_data", s_wr_data, any ? wd : 32'h0);
        end
        if (rsp_pend && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid_owner", e[32] ? m1_rvalid : m0_rvalid, 1);
            chk("rdata_owner", e[32] ? m1_rdata : m0_rdata, e[31:0]);
            chk("rvalid_other", e[32] ? m0_rvalid : m1_rvalid, 0);
            chk("rdata_other", e[32] ? m0_rdata : m1_rdata, 0);
        end else begin
            chk("rvalid0_idle", m0_rvalid, 0);
            chk("rvalid1_idle", m1_rvalid, 0);
            chk("rdata0_idle", m0_rdata, 0);
            chk("rdata1_idle", m1_rdata, 0);
        end
        chk("busy", busy, ebusy);
        if (any && !we) begin
            exp_q.push_back({eg1, nxt_rd});
            rsp_pend = 1'b1;
            pend_d = nxt_rd;
        end else begin
            rsp_pend = 1'b0;
        end
        nxt_rd = $urandom;
        @(posedge clk);
        #1;
        s_rd_data = rsp_pend ? pend_d : $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        set_m(0, 0, 0, 4'h0, 0, 0, 0);
        set_m(1, 0, 0, 4'h0, 0, 0, 0);
        s_rd_data = 32'h0;
        rsp_pend = 1'b0;
        nxt_rd = $urandom;
`ifdef PERIP_ARB_RR_EN
        tie_w = '{0, 1, 0, 1};
        w = 1;
`else
        tie_w = '{0, 0, 0, 0};
        w = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0);
        chk("state_reset", state, 0);

        // Read routing to master 0
        set_m(0, 1, 0, 4'h0, 32'h20, 0, 0);
        nxt_rd = 32'h12345678;
        tick(1, 0, 0);
        set_m(0, 0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 1);

        // Single master 1 write, then a master 0 write with no byte enables
        set_m(1, 1, 1, 4'hF, 32'h10, 32'hA5A5A5A5, 0);
        tick(0, 1, 0);
        set_m(1, 0, 0, 4'h0, 0, 0, 0);
        set_m(0, 1, 1, 4'h0, 32'h14, 32'h0BADF00D, 0);
        tick(1, 0, 0);
        set_m(0, 0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 0);

        // Tie: both masters issue reads continuously for 4 cycles
        set_m(0, 1, 0, 4'h0, 32'h100 + 4 * $urandom_range(0, 63), 0, 0);
        set_m(1, 1, 0, 4'h0, 32'h200 + 4 * $urandom_range(0, 63), 0, 0);
        for (int i = 0; i < 4; i++) tick(tie_w[i] == 0, tie_w[i] == 1, i > 0);
        set_m(0, 0, 0, 4'h0, 0, 0, 0);
        set_m(1, 0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 1);

        // Lock: m1 writes with lock 1,1,0 while m0 keeps a read pending
        set_m(1, 1, 1, 4'h3, 32'h40, $urandom, 1);
        tick(0, 1, 0);
        chk("state_own1", state, 2);
        set_m(0, 1, 0, 4'h0, 32'h44, 0, 0);
        set_m(1, 1, 1, 4'hC, 32'h48, $urandom, 1);
        tick(0, 1, 1);
        set_m(1, 1, 1, 4'hF, 32'h4C, $urandom, 0);
        tick(0, 1, 1);
        chk("state_release", state, 0);
        set_m(1, 0, 0, 4'h0, 0, 0, 0);
        tick(1, 0, 0);
        set_m(0, 0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 1);

        // Both request with lock in FREE: only the tie winner locks
        set_m(0, 1, 1, 4'hF, 32'h80, $urandom, 1);
        set_m(1, 1, 1, 4'hF, 32'h90, $urandom, 1);
        tick(w == 0, w == 1, 0);
        chk("state_tie_lock", state, w == 1 ? 2 : 1);
        set_m(w, 1, 1, 4'h1, 32'h84, $urandom, 0);
        tick(w == 0, w == 1, 1);
        chk("state_tie_rel", state, 0);
        set_m(w, 0, 0, 4'h0, 0, 0, 0);
        tick(w == 1, w == 0, 0);
        chk("state_loser_lock", state, w == 1 ? 1 : 2);
        set_m(1 - w, 0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 1);
        chk("state_drop_req", state, 0);

        // Reset the cycle after an m1 read grant: the response is dropped
        set_m(1, 1, 0, 4'h0, 32'h30, 0, 0);
        tick(0, 1, 0);
        rst_n = 1'b0;
        set_m(1, 0, 0, 4'h0, 0, 0, 0);
        #1;
        chk("rst_rvalid1", m1_rvalid, 0);
        chk("rst_rdata1", m1_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rsp_pend = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
